// File: rtl/aes_pkg.sv
// Shared AES constants for the inverse key schedule: Rcon bytes, key-size
// pairings and FSM state encoding.
package aes_pkg;

  localparam int Nk128 = 4;
  localparam int Nr128 = 10;
  localparam int Nk192 = 6;
  localparam int Nr192 = 12;
  localparam int Nk256 = 8;
  localparam int Nr256 = 14;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StEmit = 2'd1;
  localparam logic [1:0] StStep = 2'd2;

  typedef enum logic [1:0] {
    IDLE = StIdle,
    EMIT = StEmit,
    STEP = StStep
  } stateT;

  function automatic int nrForNk(input int nk);
    return nk + 6;
  endfunction

  // Round constant byte; entries outside 1..10 are never used and read as 0.
  function automatic logic [7:0] rcon(input logic [5:0] idx);
    case (idx)
      6'd1:    return 8'h01;
      6'd2:    return 8'h02;
      6'd3:    return 8'h04;
      6'd4:    return 8'h08;
      6'd5:    return 8'h10;
      6'd6:    return 8'h20;
      6'd7:    return 8'h40;
      6'd8:    return 8'h80;
      6'd9:    return 8'h1b;
      6'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational SubWord: forward AES S-box applied to each byte of a word.
module sub_word (
  input  logic [31:0] value,
  output logic [31:0] result
);

  // Row-major S-box; entry 0x00 sits in the top byte.
  localparam logic [2047:0] SboxFlat = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxFlat[{~b, 3'b000} +: 8];
  endfunction

  assign result = {sbox(value[31:24]), sbox(value[23:16]),
                   sbox(value[15:8]), sbox(value[7:0])};

endmodule

// File: rtl/inverse_key_schedule.sv
// On-the-fly AES inverse key schedule: walks the expanded key backwards from
// its last Nk words, emitting round keys Nr..0 over a valid/ready handshake.
module inverse_key_schedule
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [32*Nk-1:0] last_key,
  input  logic             key_ready,
  output logic [127:0]     round_key,
  output logic             key_valid,
  output logic [3:0]       round_idx,
  output logic             busy,
  output logic             done
);

  localparam int WinW = 32 * Nk;
  localparam int TopI = 4 * (Nr + 1) - 1;
  localparam logic [5:0] NkW = 6'(Nk);

  stateT state;
  logic [WinW-1:0] window;   // w[j] in the MSBs, w[j+Nk-1] in the LSBs
  logic [5:0] wordIdx;       // i = j + Nk - 1, index of the top window word
  logic [1:0] stepCnt;

  logic [31:0] topWord, prevWord, rotWord, subIn, subOut, tWord, newWord;
  logic [5:0] iMod, iDiv;
  logic drain;

  assign topWord  = window[31:0];
  assign prevWord = window[63:32];
  assign iMod     = wordIdx % NkW;
  assign iDiv     = wordIdx / NkW;
  assign rotWord  = {prevWord[23:0], prevWord[31:24]};
  assign subIn    = (iMod == 6'd0) ? rotWord : prevWord;
  assign drain    = (wordIdx == NkW - 6'd1);

  sub_word uSubWord (
    .value (subIn),
    .result(subOut)
  );

  always_comb begin
    tWord = prevWord;
    if (iMod == 6'd0) begin
      tWord = subOut ^ {rcon(iDiv), 24'h0};
    end else if (Nk == 8 && iMod == 6'd4) begin
      tWord = subOut;
    end
  end

  // Once w[0] has been produced the remaining steps only shift zeros in.
  assign newWord   = drain ? 32'h0 : (topWord ^ tWord);
  assign round_key = window[127:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      window    <= '0;
      wordIdx   <= '0;
      stepCnt   <= '0;
      key_valid <= 1'b0;
      round_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            window    <= last_key;
            wordIdx   <= 6'(TopI);
            round_idx <= 4'(Nr);
            busy      <= 1'b1;
            key_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            if (round_idx == 4'd0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              stepCnt <= '0;
              state   <= STEP;
            end
          end
        end
        STEP: begin
          window  <= {newWord, window[WinW-1:32]};
          stepCnt <= stepCnt + 2'd1;
          if (!drain) begin
            wordIdx <= wordIdx - 6'd1;
          end
          if (stepCnt == 2'd3) begin
            round_idx <= round_idx - 4'd1;
            key_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_key_schedule.sv
// Bench for inverse_key_schedule: AES-128/192/256 instances checked against an
// independent forward KeyExpansion model plus known FIPS-197 round keys.
module tb_inverse_key_schedule;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic startD, readyD;
  int sel;
  logic [255:0] lk;

  logic start4, start6, start8, ready4, ready6, ready8;
  logic [127:0] key4, key6, key8, key;
  logic vld4, vld6, vld8, vld;
  logic [3:0] idx4, idx6, idx8, idx;
  logic busy4, busy6, busy8, busy;
  logic done4, done6, done8, done;

  int checks = 0;
  int failures = 0;
  logic [7:0] sbox [0:255];
  logic [31:0] ew [0:59];
  logic [127:0] got [0:14];

  assign start4 = startD && (sel == 4);
  assign start6 = startD && (sel == 6);
  assign start8 = startD && (sel == 8);
  assign ready4 = readyD && (sel == 4);
  assign ready6 = readyD && (sel == 6);
  assign ready8 = readyD && (sel == 8);

  inverse_key_schedule #(.Nk(4), .Nr(10)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .last_key(lk[127:0]),
    .key_ready(ready4), .round_key(key4), .key_valid(vld4),
    .round_idx(idx4), .busy(busy4), .done(done4));
  inverse_key_schedule #(.Nk(6), .Nr(12)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .last_key(lk[191:0]),
    .key_ready(ready6), .round_key(key6), .key_valid(vld6),
    .round_idx(idx6), .busy(busy6), .done(done6));
  inverse_key_schedule #(.Nk(8), .Nr(14)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .last_key(lk),
    .key_ready(ready8), .round_key(key8), .key_valid(vld8),
    .round_idx(idx8), .busy(busy8), .done(done8));

  always_comb begin
    key = key4; vld = vld4; idx = idx4; busy = busy4; done = done4;
    if (sel == 6) begin
      key = key6; vld = vld6; idx = idx6; busy = busy6; done = done6;
    end else if (sel == 8) begin
      key = key8; vld = vld8; idx = idx8; busy = busy8; done = done8;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [7:0] rconOf(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < n; k++) r = xtime(r);
    return r;
  endfunction

  task automatic expand(input logic [255:0] k, input int nk, input int nr);
    logic [31:0] t;
    for (int i = 0; i < nk; i++) ew[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = ew[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rconOf(i / nk), 24'h0};
      else if (nk > 6 && i % nk == 4) t = subw(t);
      ew[i] = ew[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk(input int r);
    return {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
  endfunction

  function automatic logic [255:0] lastWords(input int nk, input int nr);
    logic [255:0] acc;
    acc = '0;
    for (int i = 4 * (nr + 1) - nk; i < 4 * (nr + 1); i++) acc = {acc[223:0], ew[i]};
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full ready-high run on the selected instance; keys land in got[].
  task automatic runFullSequence(input int nk, input int nr);
    int expIdx, doneCyc;
    for (int r = 0; r < 15; r++) got[r] = '0;
    lk = lastWords(nk, nr);
    readyD = 1'b1;
    startD = 1'b1;
    tick();
    startD = 1'b0;
    expIdx = nr;
    doneCyc = 0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start nk=%0d got=%b want=1", nk, busy);
    end
    for (int cyc = 1; cyc <= 5 * nr + 8; cyc++) begin
      if (vld) begin
        checks++;
        if (expIdx < 0) begin
          failures++;
          $display("FAIL extra_key nk=%0d cyc=%0d idx=%0d want=no key", nk, cyc, idx);
        end else begin
          if (idx !== 4'(expIdx) || key !== rk(expIdx) || cyc != 1 + 5 * (nr - expIdx)) begin
            failures++;
            $display("FAIL seq_key nk=%0d got idx=%0d key=%h cyc=%0d want idx=%0d key=%h cyc=%0d",
                     nk, idx, key, cyc, expIdx, rk(expIdx), 1 + 5 * (nr - expIdx));
          end
          got[expIdx] = key;
          expIdx--;
        end
      end
      if (done) begin
        checks++;
        if (doneCyc != 0 || cyc != 2 + 5 * nr) begin
          failures++;
          $display("FAIL done_timing nk=%0d got cyc=%0d want cyc=%0d (single pulse)", nk, cyc, 2 + 5 * nr);
        end
        doneCyc = cyc;
      end
      tick();
    end
    checks++;
    if (expIdx != -1 || doneCyc != 2 + 5 * nr || busy !== 1'b0) begin
      failures++;
      $display("FAIL run_end nk=%0d got keysLeft=%0d doneCyc=%0d busy=%b want keysLeft=-1 doneCyc=%0d busy=0",
               nk, expIdx, doneCyc, busy, 2 + 5 * nr);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 4;
    reset = 1'b1;
    startD = 1'b1;
    tick();
    tick();
    checks++;
    if (vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got vld=%b busy=%b done=%b want 0 0 0", vld, busy, done);
    end
    checks++;
    if (key !== 128'h0 || idx !== 4'h0) begin
      failures++;
      $display("FAIL reset_data got key=%h idx=%0d want 0 0", key, idx);
    end
    checks++;
    if ({vld6, vld8, busy6, busy8} !== 4'b0) begin
      failures++;
      $display("FAIL reset_others got %b want 0000", {vld6, vld8, busy6, busy8});
    end
    reset = 1'b0;
    startD = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || vld !== 1'b0) begin
      failures++;
      $display("FAIL start_in_reset got busy=%b vld=%b want 0 0", busy, vld);
    end
  endtask

  task automatic test_aes128();
    sel = 4;
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    runFullSequence(4, 10);
    checks++;
    if (got[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      failures++;
      $display("FAIL aes128_r10 got=%h want=13111d7fe3944a17f307a78b4d2b30c5", got[10]);
    end
    checks++;
    if (got[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
      failures++;
      $display("FAIL aes128_r0 got=%h want=000102030405060708090a0b0c0d0e0f", got[0]);
    end
  endtask

  task automatic test_aes192();
    sel = 6;
    expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
    runFullSequence(6, 12);
    checks++;
    if (got[12] !== 128'ha4970a331a78dc09c418c271e3a41d5d) begin
      failures++;
      $display("FAIL aes192_r12 got=%h want=a4970a331a78dc09c418c271e3a41d5d", got[12]);
    end
    checks++;
    if (got[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
      failures++;
      $display("FAIL aes192_r0 got=%h want=000102030405060708090a0b0c0d0e0f", got[0]);
    end
  endtask

  task automatic test_aes256();
    sel = 8;
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    runFullSequence(8, 14);
    checks++;
    if (got[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
      failures++;
      $display("FAIL aes256_r14 got=%h want=24fc79ccbf0979e9371ac23c6d68de36", got[14]);
    end
    checks++;
    if (got[0] !== 128'h000102030405060708090a0b0c0d0e0f) begin
      failures++;
      $display("FAIL aes256_r0 got=%h want=000102030405060708090a0b0c0d0e0f", got[0]);
    end
  endtask

  task automatic test_backpressure();
    int expIdx, doneCyc;
    bit hold;
    logic [127:0] hKey;
    logic [3:0] hIdx;
    sel = 4;
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    lk = lastWords(4, 10);
    readyD = 1'b1;
    startD = 1'b1;
    tick();
    startD = 1'b0;
    expIdx = 10;
    doneCyc = 0;
    hold = 1'b0;
    for (int cyc = 1; cyc <= 400 && doneCyc == 0; cyc++) begin
      readyD = ($urandom_range(0, 1) == 1);
      startD = (cyc == 17);
      if (hold) begin
        checks++;
        if (vld !== 1'b1 || key !== hKey || idx !== hIdx) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got vld=%b idx=%0d key=%h want vld=1 idx=%0d key=%h",
                   cyc, vld, idx, key, hIdx, hKey);
        end
      end
      hold = 1'b0;
      if (vld && !readyD) begin
        hold = 1'b1;
        hKey = key;
        hIdx = idx;
      end
      if (vld && readyD) begin
        checks++;
        if (expIdx < 0 || idx !== 4'(expIdx) || key !== rk(expIdx < 0 ? 0 : expIdx)) begin
          failures++;
          $display("FAIL bp_key cyc=%0d got idx=%0d key=%h want idx=%0d key=%h",
                   cyc, idx, key, expIdx, rk(expIdx < 0 ? 0 : expIdx));
        end
        expIdx--;
      end
      if (done) doneCyc = cyc;
      tick();
    end
    startD = 1'b0;
    readyD = 1'b1;
    checks++;
    if (expIdx != -1 || doneCyc == 0) begin
      failures++;
      $display("FAIL bp_complete got keysLeft=%0d doneCyc=%0d want keysLeft=-1 doneCyc>0", expIdx, doneCyc);
    end
    tick();
    tick();
    checks++;
    if (vld !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_while_busy got vld=%b busy=%b want 0 0", vld, busy);
    end
  endtask

  task automatic test_reset_midrun();
    bit sawDone;
    sel = 4;
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    lk = lastWords(4, 10);
    readyD = 1'b1;
    startD = 1'b1;
    tick();
    startD = 1'b0;
    for (int c = 1; c < 23; c++) tick();
    checks++;
    if (vld !== 1'b0 || idx !== 4'd6 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_step got vld=%b idx=%0d busy=%b want 0 6 1", vld, idx, busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (vld !== 1'b0 || busy !== 1'b0 || key !== 128'h0) begin
      failures++;
      $display("FAIL async_reset got vld=%b busy=%b key=%h want 0 0 0", vld, busy, key);
    end
    sawDone = 1'b0;
    tick();
    if (done) sawDone = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) sawDone = 1'b1;
    end
    checks++;
    if (sawDone || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done got done=%b busy=%b want 0 0", sawDone, busy);
    end
    runFullSequence(4, 10);
  endtask

  initial begin
    reset = 1'b1;
    startD = 1'b0;
    readyD = 1'b0;
    sel = 4;
    lk = '0;
    buildSbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_backpressure();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
